// File: rtl/pal_registered.sv
// Field-programmable PAL: per-output sum of N_TERMS product terms over inputs and
// macrocell feedback, registered/combinational macrocells, lockable config port.
module pal_registered #(
    parameter  int N_IN    = 4,
    parameter  int N_OUT   = 2,
    parameter  int N_TERMS = 4,
    localparam int FW      = 2 * (N_IN + N_OUT),
    localparam int N_ROWS  = N_OUT * N_TERMS + N_OUT,
    localparam int AW      = $clog2(N_ROWS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IN-1:0]   inputs,
    output logic [N_OUT-1:0]  outputs,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [FW-1:0]     cfg_wdata,
    input  logic              cfg_lock,
    output logic              cfg_err,
    output logic [FW-1:0]     cfg_rdata
);

    localparam int          N_LIT = N_IN + N_OUT;
    localparam int unsigned TROWS = N_OUT * N_TERMS;

    logic [FW-1:0]    r_fuse [N_ROWS];
    logic [N_OUT-1:0] r_q;
    logic             r_locked;
    logic             r_err;

    logic [N_LIT-1:0] w_lit;
    logic [N_OUT-1:0] w_sum;
    logic [N_OUT-1:0] w_d;
    logic [N_OUT-1:0] w_inv;
    logic [N_OUT-1:0] w_mode;
    logic [FW-1:0]    w_row;
    logic             w_term;
    logic             w_accept;
    logic             w_hit;
    logic [FW-1:0]    w_rdata;

    // Feedback is always taken from the macrocell registers, so no comb loop exists.
    assign w_lit = {r_q, inputs};

    always_comb begin
        w_sum  = '0;
        w_row  = '0;
        w_term = 1'b0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            for (int unsigned t = 0; t < N_TERMS; t++) begin
                w_row  = r_fuse[k * N_TERMS + t];
                w_term = |w_row;
                for (int unsigned j = 0; j < N_LIT; j++) begin
                    if ((w_row[2*j] && !w_lit[j]) || (w_row[2*j+1] && w_lit[j])) begin
                        w_term = 1'b0;
                    end
                end
                w_sum[k] = w_sum[k] | w_term;
            end
        end
    end

    always_comb begin
        w_inv  = '0;
        w_mode = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            w_mode[k] = r_fuse[TROWS + k][0];
            w_inv[k]  = r_fuse[TROWS + k][1];
        end
    end

    assign w_d     = w_sum ^ w_inv;
    assign outputs = (w_mode & r_q) | (~w_mode & w_d);

    always_comb begin
        w_hit   = 1'b0;
        w_rdata = '0;
        for (int unsigned i = 0; i < N_ROWS; i++) begin
            if (cfg_addr == AW'(i)) begin
                w_hit   = 1'b1;
                w_rdata = r_fuse[i];
            end
        end
    end

    assign cfg_ready = ~r_locked;
    assign cfg_rdata = r_locked ? '0 : w_rdata;
    assign cfg_err   = r_err;
    assign w_accept  = cfg_valid & ~r_locked;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_ROWS; i++) begin
                r_fuse[i] <= '0;
            end
        end else if (w_accept) begin
            for (int unsigned i = 0; i < N_ROWS; i++) begin
                if (cfg_addr == AW'(i)) begin
                    // Macrocell rows keep only reg_mode/inv; upper bits read back as 0.
                    r_fuse[i] <= (i >= TROWS) ? {{(FW-2){1'b0}}, cfg_wdata[1:0]} : cfg_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q      <= '0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_q      <= w_d;
            r_locked <= r_locked | cfg_lock;
            r_err    <= w_accept & ~w_hit;
        end
    end

endmodule
